// File: rtl/dm_cache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache controller, one word per line.
// Optional hit/miss statistics counters are enabled by defining CACHE_STATS_EN.
//
// state | meaning
// IDLE  | evaluate the cpu request: hit -> RESP, clean miss -> FILL, dirty miss -> WB
// WB    | writing the dirty victim line back, waiting for mem_ready
// FILL  | reading the requested line from memory, waiting for mem_ready
// RESP  | hit pulse cycle; cpu advances on the closing edge
module dm_cache_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int INDEX_W = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] Write_Data,
  output logic [DATA_W-1:0] rData,
  output logic              hit,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt
`endif
);

  localparam int TAG_W = ADDR_W - INDEX_W - 2;
  localparam int LINES = 2 ** INDEX_W;

  typedef enum logic [1:0] {IDLE, WB, FILL, RESP} state_t;

  state_t state_q, state_d;

  logic [TAG_W-1:0]  tag_arr  [LINES];
  logic [DATA_W-1:0] data_arr [LINES];
  logic [LINES-1:0]  valid_q, valid_d;
  logic [LINES-1:0]  dirty_q, dirty_d;

  logic              hit_d, mem_read_d, mem_write_d;
  logic [DATA_W-1:0] rdata_d, mem_wdata_d;
  logic [ADDR_W-1:0] mem_addr_d;

  logic               req;
  logic               tag_hit;
  logic [INDEX_W-1:0] req_idx, mem_idx;
  logic [TAG_W-1:0]   req_tag, mem_tag;

  logic               line_we;
  logic [INDEX_W-1:0] line_idx;
  logic [DATA_W-1:0]  line_data;
  logic [TAG_W-1:0]   line_tag;

  logic unused_offset;
  assign unused_offset = ^Address[1:0];

  assign req     = read | write;
  assign req_idx = Address[INDEX_W+1:2];
  assign req_tag = Address[ADDR_W-1:INDEX_W+2];
  assign tag_hit = valid_q[req_idx] && (tag_arr[req_idx] == req_tag);

  // Refill/write-back target comes from the registered memory address, so a
  // request that changes mid-miss cannot corrupt the line being serviced.
  assign mem_idx = mem_addr[INDEX_W+1:2];
  assign mem_tag = mem_addr[ADDR_W-1:INDEX_W+2];

  always_comb begin
    state_d     = state_q;
    hit_d       = hit;
    rdata_d     = rData;
    mem_read_d  = mem_read;
    mem_write_d = mem_write;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    line_we     = 1'b0;
    line_idx    = req_idx;
    line_data   = Write_Data;
    line_tag    = req_tag;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (tag_hit) begin
            hit_d   = 1'b1;
            state_d = RESP;
            if (write) begin
              line_we          = 1'b1;
              dirty_d[req_idx] = 1'b1;
            end else begin
              rdata_d = data_arr[req_idx];
            end
          end else if (valid_q[req_idx] && dirty_q[req_idx]) begin
            mem_write_d = 1'b1;
            mem_addr_d  = {tag_arr[req_idx], req_idx, 2'b00};
            mem_wdata_d = data_arr[req_idx];
            state_d     = WB;
          end else begin
            mem_read_d = 1'b1;
            mem_addr_d = {req_tag, req_idx, 2'b00};
            state_d    = FILL;
          end
        end
      end
      WB: begin
        if (mem_ready) begin
          mem_write_d      = 1'b0;
          dirty_d[mem_idx] = 1'b0;
          mem_read_d       = 1'b1;
          mem_addr_d       = {req_tag, req_idx, 2'b00};
          state_d          = FILL;
        end
      end
      FILL: begin
        if (mem_ready) begin
          line_we          = 1'b1;
          line_idx         = mem_idx;
          line_data        = mem_rdata;
          line_tag         = mem_tag;
          valid_d[mem_idx] = 1'b1;
          dirty_d[mem_idx] = 1'b0;
          mem_read_d       = 1'b0;
          state_d          = IDLE;
        end
      end
      RESP: begin
        hit_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      valid_q   <= '0;
      dirty_q   <= '0;
      hit       <= 1'b0;
      rData     <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      dirty_q   <= dirty_d;
      hit       <= hit_d;
      rData     <= rdata_d;
      mem_read  <= mem_read_d;
      mem_write <= mem_write_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
    end
  end

  // Tag/data storage is not reset; valid bits alone qualify it.
  always_ff @(posedge clock) begin
    if (line_we && !reset) begin
      data_arr[line_idx] <= line_data;
      tag_arr[line_idx]  <= line_tag;
    end
  end

`ifdef CACHE_STATS_EN
  // The hit that follows a refill belongs to an already-counted miss.
  logic fill_done_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      fill_done_q <= 1'b0;
      hit_cnt     <= '0;
      miss_cnt    <= '0;
    end else begin
      fill_done_q <= (state_q == FILL) && mem_ready;
      if ((state_q == IDLE) && req && tag_hit && !fill_done_q)
        hit_cnt <= hit_cnt + 16'd1;
      if ((state_q == IDLE) && req && !tag_hit)
        miss_cnt <= miss_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Self-checking bench for dm_cache_ctrl: vector table, reset-abort sequence and a
// random-latency cpu trace, with a memory responder model and a response scoreboard.
module tb_dm_cache_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        read = 1'b0, write = 1'b0;
  logic [7:0]  Address = '0;
  logic [31:0] Write_Data = '0;
  logic [31:0] rData, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        hit, mem_read, mem_write;
  logic        mem_ready = 1'b0;
  logic [7:0]  mem_addr;
`ifdef CACHE_STATS_EN
  logic [15:0] hit_cnt, miss_cnt;
`endif

  always #5 clock = ~clock;

  dm_cache_ctrl dut (
    .clock(clock), .reset(reset), .read(read), .write(write),
    .Address(Address), .Write_Data(Write_Data), .rData(rData), .hit(hit),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
`ifdef CACHE_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Backing memory model
  logic [31:0] mem_model [64];
  int          lat_cfg = 3;
  bit          rand_lat = 1'b0;
  bit          busy = 1'b0;
  int          wcnt = 0, cur_lat = 0;
  int          n_mrd = 0, n_mwr = 0;
  logic [7:0]  last_rd_addr = '0, last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;

  always @(negedge clock) begin
    if (reset) begin
      mem_ready = 1'b0;
      busy = 1'b0;
      wcnt = 0;
    end else if (mem_ready) begin
      mem_ready = 1'b0;
      busy = 1'b0;
    end else if (mem_read || mem_write) begin
      if (!busy) begin
        busy = 1'b1;
        wcnt = 0;
        cur_lat = rand_lat ? int'($urandom_range(0, 2)) : lat_cfg;
      end
      if (wcnt >= cur_lat) begin
        mem_ready = 1'b1;
        if (mem_write) begin
          mem_model[mem_addr[7:2]] = mem_wdata;
          last_wr_addr = mem_addr;
          last_wr_data = mem_wdata;
          n_mwr++;
        end else begin
          mem_rdata = mem_model[mem_addr[7:2]];
          last_rd_addr = mem_addr;
          n_mrd++;
        end
      end else begin
        wcnt++;
      end
    end
  end

  // Protocol monitor
  int hit_total = 0;
  logic prev_hit = 1'b0;
  always @(negedge clock) begin
    if (!reset) begin
      chk("mem_rd_wr_exclusive", {31'b0, mem_read & mem_write}, 32'd0);
      if (hit) begin
        hit_total++;
        chk("single_cycle_hit", {31'b0, prev_hit}, 32'd0);
      end
    end
    prev_hit = hit;
  end

  typedef struct {
    bit          is_rd;
    logic [31:0] data;
  } exp_t;
  exp_t sb_q[$];

  task automatic do_req(input bit rd, input bit wr, input logic [7:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_d, input int exp_lat, input string nm);
    exp_t e;
    int   cyc;
    bit   got;
    e.is_rd = rd && !wr;
    e.data  = exp_d;
    sb_q.push_back(e);
    read = rd; write = wr; Address = a; Write_Data = wd;
    cyc = 0; got = 1'b0;
    while (!got && cyc < 300) begin
      @(posedge clock); #1;
      cyc++;
      got = hit;
    end
    read = 1'b0; write = 1'b0;
    e = sb_q.pop_front();
    chk({nm, "_completed"}, {31'b0, got}, 32'd1);
    if (got && e.is_rd) chk({nm, "_rdata"}, rData, e.data);
    if (exp_lat >= 0) chk({nm, "_latency"}, cyc, exp_lat);
  endtask

  typedef struct {
    bit          rd;
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_d;
    int          exp_lat;
    int          exp_nrd;
    int          exp_nwr;
    logic [7:0]  exp_rd_addr;
    logic [7:0]  exp_wr_addr;
    logic [31:0] exp_wr_data;
  } vec_t;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
  } tr_t;

  vec_t        vt [8];
  tr_t         trace [10];
  logic [31:0] ref_mem [64];

  initial begin
    int r0, w0, h0;
    logic [31:0] exp_d;

    for (int i = 0; i < 64; i++) mem_model[i] = 32'h100 + 32'(i * 3);
    mem_model[9] = 32'd588;

    // clean fill; write-miss; hit; dirty eviction; read+write; dirty proof; refetch
    vt[0] = '{1, 0, 8'h24, 32'd0,   32'd588, 6,  1, 0, 8'h24, 8'h00, 32'd0};
    vt[1] = '{0, 1, 8'hA4, 32'd716, 32'd0,   6,  1, 0, 8'hA4, 8'h00, 32'd0};
    vt[2] = '{1, 0, 8'hA4, 32'd0,   32'd716, 1,  0, 0, 8'h00, 8'h00, 32'd0};
    vt[3] = '{1, 0, 8'h24, 32'd0,   32'd588, 11, 1, 1, 8'h24, 8'hA4, 32'd716};
    vt[4] = '{1, 1, 8'h60, 32'd751, 32'd0,   6,  1, 0, 8'h60, 8'h00, 32'd0};
    vt[5] = '{1, 0, 8'h60, 32'd0,   32'd751, 1,  0, 0, 8'h00, 8'h00, 32'd0};
    vt[6] = '{1, 0, 8'hE0, 32'd0,   32'h1A8, 11, 1, 1, 8'hE0, 8'h60, 32'd751};
    vt[7] = '{1, 0, 8'h60, 32'd0,   32'd751, 6,  1, 0, 8'h60, 8'h00, 32'd0};

    trace[0] = '{0, 1, 8'h10, 32'hAAAA0001};
    trace[1] = '{1, 0, 8'h10, 32'd0};
    trace[2] = '{1, 0, 8'h50, 32'd0};
    trace[3] = '{0, 1, 8'h14, 32'hBBBB0002};
    trace[4] = '{0, 1, 8'h54, 32'hCCCC0003};
    trace[5] = '{1, 0, 8'h14, 32'd0};
    trace[6] = '{1, 0, 8'h54, 32'd0};
    trace[7] = '{1, 1, 8'h18, 32'hDDDD0004};
    trace[8] = '{1, 0, 8'h98, 32'd0};
    trace[9] = '{1, 0, 8'h18, 32'd0};

    repeat (3) @(posedge clock);
    #1;
    chk("reset_hit", {31'b0, hit}, 32'd0);
    chk("reset_rData", rData, 32'd0);
    chk("reset_mem_read", {31'b0, mem_read}, 32'd0);
    chk("reset_mem_write", {31'b0, mem_write}, 32'd0);
    chk("reset_mem_addr", {24'b0, mem_addr}, 32'd0);
    chk("reset_mem_wdata", mem_wdata, 32'd0);
`ifdef CACHE_STATS_EN
    chk("reset_hit_cnt", {16'b0, hit_cnt}, 32'd0);
    chk("reset_miss_cnt", {16'b0, miss_cnt}, 32'd0);
`endif
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      r0 = n_mrd; w0 = n_mwr;
      do_req(vt[i].rd, vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].exp_d, vt[i].exp_lat,
             $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_mem_reads", i), n_mrd - r0, vt[i].exp_nrd);
      chk($sformatf("vec%0d_mem_writes", i), n_mwr - w0, vt[i].exp_nwr);
      if (vt[i].exp_nrd > 0)
        chk($sformatf("vec%0d_fill_addr", i), {24'b0, last_rd_addr}, {24'b0, vt[i].exp_rd_addr});
      if (vt[i].exp_nwr > 0) begin
        chk($sformatf("vec%0d_wb_addr", i), {24'b0, last_wr_addr}, {24'b0, vt[i].exp_wr_addr});
        chk($sformatf("vec%0d_wb_data", i), last_wr_data, vt[i].exp_wr_data);
      end
      @(posedge clock); #1;
    end
    chk("table_hit_pulses", hit_total, 8);

    // Reset during FILL aborts the refill and invalidates every line
    lat_cfg = 5;
    read = 1'b1; Address = 8'h28;
    repeat (3) @(posedge clock);
    #1;
    chk("abort_fill_pending", {31'b0, mem_read}, 32'd1);
    reset = 1'b1; read = 1'b0;
    @(posedge clock); #1;
    chk("abort_mem_read", {31'b0, mem_read}, 32'd0);
    chk("abort_mem_write", {31'b0, mem_write}, 32'd0);
    chk("abort_hit", {31'b0, hit}, 32'd0);
    chk("abort_rData", rData, 32'd0);
    reset = 1'b0;
    lat_cfg = 3;
    r0 = n_mrd;
    do_req(1'b1, 1'b0, 8'h24, 32'd0, 32'd588, 6, "post_reset_24");
    chk("post_reset_24_missed", n_mrd - r0, 1);
    @(posedge clock); #1;
    r0 = n_mrd;
    do_req(1'b1, 1'b0, 8'h28, 32'd0, 32'h100 + 32'd30, 6, "post_reset_28");
    chk("post_reset_28_missed", n_mrd - r0, 1);

    // Back-to-back cpu trace with random memory latency
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = mem_model[i];
    rand_lat = 1'b1;
    h0 = hit_total;
    for (int i = 0; i < 10; i++) begin
      if (trace[i].wr) begin
        ref_mem[trace[i].addr[7:2]] = trace[i].wdata;
        exp_d = 32'd0;
      end else begin
        exp_d = ref_mem[trace[i].addr[7:2]];
      end
      do_req(trace[i].rd, trace[i].wr, trace[i].addr, trace[i].wdata, exp_d, -1,
             $sformatf("trace%0d", i));
    end
    repeat (2) @(posedge clock);
    #1;
    chk("trace_hit_pulses", hit_total - h0, 10);
`ifdef CACHE_STATS_EN
    chk("trace_hit_plus_miss", 32'(hit_cnt) + 32'(miss_cnt), 32'd10);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
